// File: rtl/ex_stage_md_pkg.sv
// rtl/ex_stage_md_pkg.sv - shared EX-stage encodings; EX_DIVIDER_EN enables the divide opcodes
package ex_stage_md_pkg;

    localparam logic [3:0] ALU_OP_NOP  = 4'd0;
    localparam logic [3:0] ALU_OP_AND  = 4'd1;
    localparam logic [3:0] ALU_OP_OR   = 4'd2;
    localparam logic [3:0] ALU_OP_XOR  = 4'd3;
    localparam logic [3:0] ALU_OP_ADDS = 4'd4;
    localparam logic [3:0] ALU_OP_ADDU = 4'd5;
    localparam logic [3:0] ALU_OP_SUBS = 4'd6;
    localparam logic [3:0] ALU_OP_SUBU = 4'd7;
    localparam logic [3:0] ALU_OP_SHRL = 4'd8;
    localparam logic [3:0] ALU_OP_SHLL = 4'd9;
    localparam logic [3:0] ALU_OP_MULU = 4'd10;
    localparam logic [3:0] ALU_OP_DIVU = 4'd11;
    localparam logic [3:0] ALU_OP_REMU = 4'd12;

    localparam logic [1:0] MEM_OP_NOP  = 2'd0;
    localparam logic [1:0] CTRL_OP_NOP = 2'd0;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;

    typedef enum logic [1:0] {
        MD_STATE_IDLE = 2'd0,
        MD_STATE_BUSY = 2'd1,
        MD_STATE_DONE = 2'd2
    } MdStateBus;

    typedef logic [4:0] MdCntBus;

    // Opcodes that go through the iterative engine instead of the ALU.
    function automatic logic is_md_op(input logic [3:0] op);
`ifdef EX_DIVIDER_EN
        return (op == ALU_OP_MULU) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
`else
        return (op == ALU_OP_MULU);
`endif
    endfunction

endpackage

// File: rtl/ex_md_unit.sv
// rtl/ex_md_unit.sv - iterative shift-add multiplier, one bit per cycle
// EX_DIVIDER_EN adds a restoring divider sharing the same registers and latency.
module ex_md_unit
    import ex_stage_md_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        hold,
    input  logic [3:0]  op,
    input  logic [31:0] in_0,
    input  logic [31:0] in_1,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    MdStateBus   state;
    MdCntBus     cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

`ifdef EX_DIVIDER_EN
    // Divide reuses acc as partial remainder, mplier as dividend/quotient, mcand as divisor.
    logic [3:0]  op_q;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        div_ge;

    assign rem_sh   = {acc, mplier[31]};
    assign rem_diff = rem_sh - {1'b0, mcand};
    assign div_ge   = (rem_sh >= {1'b0, mcand});
`endif

    assign busy = (state == MD_STATE_BUSY);
    assign done = (state == MD_STATE_DONE);

`ifdef EX_DIVIDER_EN
    assign result = (op_q == ALU_OP_DIVU) ? mplier : acc;
`else
    assign result = acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_STATE_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`ifdef EX_DIVIDER_EN
            op_q   <= ALU_OP_MULU;
`endif
        end else if (abort) begin
            state <= MD_STATE_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_STATE_IDLE: begin
                    if (start && is_md_op(op)) begin
                        state <= MD_STATE_BUSY;
                        cnt   <= '0;
                        acc   <= '0;
`ifdef EX_DIVIDER_EN
                        op_q <= op;
                        if (op == ALU_OP_MULU) begin
                            mcand  <= in_0;
                            mplier <= in_1;
                        end else begin
                            mcand  <= in_1;
                            mplier <= in_0;
                        end
`else
                        mcand  <= in_0;
                        mplier <= in_1;
`endif
                    end
                end
                MD_STATE_BUSY: begin
`ifdef EX_DIVIDER_EN
                    if (op_q != ALU_OP_MULU) begin
                        acc    <= div_ge ? rem_diff[31:0] : rem_sh[31:0];
                        mplier <= {mplier[30:0], div_ge};
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= {mcand[30:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                    end
`else
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
`endif
                    if (cnt == MdCntBus'(MD_ITER - 1)) begin
                        state <= MD_STATE_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MD_STATE_DONE: begin
                    if (!hold) state <= MD_STATE_IDLE;
                end
                default: state <= MD_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - EX stage: ALU, iterative multiply engine, EX/MEM register
// EX_DIVIDER_EN adds DIVU/REMU through the same engine.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] id_pc,
    input  logic        id_en,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic        id_br_flag,
    input  logic [1:0]  id_mem_op,
    input  logic [31:0] id_mem_wr_data,
    input  logic [1:0]  id_ctrl_op,
    input  logic [4:0]  id_dst_addr,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] fwd_data,
    output logic        ex_stall_req,
    output logic [29:0] ex_pc,
    output logic        ex_en,
    output logic        ex_br_flag,
    output logic [1:0]  ex_mem_op,
    output logic [31:0] ex_mem_wr_data,
    output logic [1:0]  ex_ctrl_op,
    output logic [4:0]  ex_dst_addr,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [31:0] ex_out
);

    logic        md_pending;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_out;
    logic        ovf;
    logic [2:0]  exp_next;

    assign md_pending = id_en && is_md_op(id_alu_op);

    ex_md_unit #(
        .MD_ITER (MD_ITER)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (md_pending && !flush),
        .abort  (flush),
        .hold   (stall),
        .op     (id_alu_op),
        .in_0   (id_alu_in_0),
        .in_1   (id_alu_in_1),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // DONE drops the request so the finished op can load EX/MEM like a normal instruction.
    assign ex_stall_req = (!md_busy && !md_done && md_pending) || md_busy;

    assign sum  = id_alu_in_0 + id_alu_in_1;
    assign diff = id_alu_in_0 - id_alu_in_1;

    always_comb begin
        alu_out = '0;
        ovf     = 1'b0;
        case (id_alu_op)
            ALU_OP_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
            ALU_OP_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
            ALU_OP_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
            ALU_OP_ADDS: begin
                alu_out = sum;
                ovf     = (id_alu_in_0[31] == id_alu_in_1[31]) && (sum[31] != id_alu_in_0[31]);
            end
            ALU_OP_ADDU: alu_out = sum;
            ALU_OP_SUBS: begin
                alu_out = diff;
                ovf     = (id_alu_in_0[31] != id_alu_in_1[31]) && (diff[31] != id_alu_in_0[31]);
            end
            ALU_OP_SUBU: alu_out = diff;
            ALU_OP_SHRL: alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
            ALU_OP_SHLL: alu_out = id_alu_in_0 << id_alu_in_1[4:0];
            default:     alu_out = '0;
        endcase
    end

    assign fwd_data = md_done ? md_result : alu_out;
    assign exp_next = (ovf && (id_exp_code == ISA_EXP_NO_EXP)) ? ISA_EXP_OVERFLOW : id_exp_code;

    always_ff @(posedge clk) begin
        if (reset || (!stall && (flush || ex_stall_req))) begin
            ex_pc          <= '0;
            ex_en          <= 1'b0;
            ex_br_flag     <= 1'b0;
            ex_mem_op      <= MEM_OP_NOP;
            ex_mem_wr_data <= '0;
            ex_ctrl_op     <= CTRL_OP_NOP;
            ex_dst_addr    <= '0;
            ex_gpr_we_     <= 1'b1;
            ex_exp_code    <= ISA_EXP_NO_EXP;
            ex_out         <= '0;
        end else if (!stall) begin
            ex_pc          <= id_pc;
            ex_en          <= id_en;
            ex_br_flag     <= id_br_flag;
            ex_mem_op      <= id_mem_op;
            ex_mem_wr_data <= id_mem_wr_data;
            ex_ctrl_op     <= id_ctrl_op;
            ex_dst_addr    <= id_dst_addr;
            ex_gpr_we_     <= id_gpr_we_;
            ex_exp_code    <= exp_next;
            ex_out         <= fwd_data;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - randomized bench for ex_stage_md against an arithmetic model
// Builds with or without EX_DIVIDER_EN.
module tb_ex_stage_md;
    import ex_stage_md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] id_pc;
    logic        id_en;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;
    logic        stall;
    logic        flush;
    logic [31:0] fwd_data;
    logic        ex_stall_req;
    logic [29:0] ex_pc;
    logic        ex_en;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;

    int vectors = 0;
    int miscompares = 0;

    ex_stage_md dut (
        .clk(clk), .reset(reset), .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
        .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_br_flag(id_br_flag),
        .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
        .stall(stall), .flush(flush), .fwd_data(fwd_data), .ex_stall_req(ex_stall_req),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
    );

    always #5 clk = ~clk;

    // Reference model: the architectural meaning of each opcode in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:       return a & b;
            4'd2:       return a | b;
            4'd3:       return a ^ b;
            4'd4, 4'd5: return a + b;
            4'd6, 4'd7: return a - b;
            4'd8:       return a >> (b % 32);
            4'd9:       return a << (b % 32);
            4'd10:      return a * b;
`ifdef EX_DIVIDER_EN
            4'd11:      return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12:      return (b == 0) ? a : a % b;
`endif
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] exc);
        longint sa, sb, r;
        logic [31:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd4) r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else return exc;
        t = r[31:0];
        if (r != longint'($signed(t)) && exc == 3'd0) return 3'd3;
        return exc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_en = 1'b0; id_alu_op = 4'd0; id_alu_in_0 = '0; id_alu_in_1 = '0; id_pc = '0;
        id_br_flag = 1'b0; id_mem_op = 2'd0; id_mem_wr_data = '0; id_ctrl_op = 2'd0;
        id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = 3'd0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] exc);
        id_en = 1'b1; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b; id_exp_code = exc;
        id_pc = 30'($urandom); id_br_flag = 1'($urandom); id_mem_op = 2'($urandom);
        id_mem_wr_data = $urandom; id_ctrl_op = 2'($urandom); id_dst_addr = 5'($urandom);
        id_gpr_we_ = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_idle();
        step(); step();
        reset = 1'b0;
        drive(ALU_OP_ADDU, 32'h1234_5678, 32'h1111_1111, 3'd5);
        step();
        reset = 1'b1;
        step();
        set_idle();
        vectors++;
        if ({ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields got pc=%h mem_op=%h wd=%h dst=%h expected all zero", ex_pc, ex_mem_op, ex_mem_wr_data, ex_dst_addr);
        end
        vectors++;
        if (ex_en !== 1'b0) begin miscompares++; $display("FAIL reset_ex_en got %b expected 0", ex_en); end
        vectors++;
        if (ex_gpr_we_ !== 1'b1) begin miscompares++; $display("FAIL reset_gpr_we_ got %b expected 1", ex_gpr_we_); end
        vectors++;
        if (ex_exp_code !== 3'd0) begin miscompares++; $display("FAIL reset_exp_code got %0d expected 0", ex_exp_code); end
        vectors++;
        if (ex_out !== 32'd0) begin miscompares++; $display("FAIL reset_ex_out got %h expected 0", ex_out); end
        reset = 1'b0;
        #1;
        vectors++;
        if (ex_stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall_req got %b expected 0", ex_stall_req); end
        // Reset in the middle of a multiply must abandon it.
        drive(ALU_OP_MULU, 32'h0000_0007, 32'h0000_0009, 3'd0);
        repeat (5) step();
        reset = 1'b1;
        set_idle();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (ex_stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_engine_stall got %b expected 0", ex_stall_req); end
        repeat (40) step();
        vectors++;
        if (ex_out !== 32'd0 || ex_en !== 1'b0) begin
            miscompares++; $display("FAIL reset_engine_result got out=%h en=%b expected 0/0", ex_out, ex_en);
        end
    endtask

    task automatic test_alu_directed();
        drive(ALU_OP_ADDU, 32'h0000_0003, 32'hFFFF_FFFF, ISA_EXP_NO_EXP);
        #1;
        vectors++;
        if (fwd_data !== 32'h2 || ex_stall_req !== 1'b0) begin
            miscompares++; $display("FAIL addu_fwd got %h stall=%b expected 2/0", fwd_data, ex_stall_req);
        end
        step();
        vectors++;
        if (ex_out !== 32'h2 || ex_en !== 1'b1 || ex_exp_code !== 3'd0) begin
            miscompares++; $display("FAIL addu_load got out=%h en=%b exp=%0d expected 2/1/0", ex_out, ex_en, ex_exp_code);
        end
        drive(ALU_OP_ADDS, 32'h7FFF_FFFF, 32'h1, ISA_EXP_NO_EXP);
        step();
        vectors++;
        if (ex_out !== 32'h8000_0000 || ex_exp_code !== 3'd3) begin
            miscompares++; $display("FAIL adds_ovf got out=%h exp=%0d expected 80000000/3", ex_out, ex_exp_code);
        end
        drive(ALU_OP_ADDS, 32'h7FFF_FFFF, 32'h1, ISA_EXP_UNDEF_INSN);
        step();
        vectors++;
        if (ex_exp_code !== 3'd2) begin miscompares++; $display("FAIL adds_keep_exp got %0d expected 2", ex_exp_code); end
        drive(ALU_OP_SUBS, 32'h8000_0000, 32'h1, ISA_EXP_NO_EXP);
        step();
        vectors++;
        if (ex_out !== 32'h7FFF_FFFF || ex_exp_code !== 3'd3) begin
            miscompares++; $display("FAIL subs_ovf got out=%h exp=%0d expected 7fffffff/3", ex_out, ex_exp_code);
        end
        set_idle();
    endtask

    task automatic test_alu_random();
        logic [31:0] corners [6];
        logic [31:0] a, b, exp_res;
        logic [3:0]  op;
        logic [2:0]  exc, exp_exc;
        logic [76:0] exp_pass;
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 9));
            a   = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b   = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            exc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
            drive(op, a, b, exc);
            id_en = ($urandom_range(0, 7) != 0);
            exp_res  = ref_result(op, a, b);
            exp_exc  = ref_exp(op, a, b, exc);
            exp_pass = {id_pc, id_en, id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_};
            #1;
            vectors++;
            if (fwd_data !== exp_res || ex_stall_req !== 1'b0) begin
                miscompares++; $display("FAIL alu_fwd op=%0d got %h stall=%b expected %h/0", op, fwd_data, ex_stall_req, exp_res);
            end
            step();
            vectors++;
            if (ex_out !== exp_res || ex_exp_code !== exp_exc) begin
                miscompares++; $display("FAIL alu_load op=%0d a=%h b=%h got %h/%0d expected %h/%0d", op, a, b, ex_out, ex_exp_code, exp_res, exp_exc);
            end
            vectors++;
            if ({ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_} !== exp_pass) begin
                miscompares++; $display("FAIL alu_passthru got pc=%h en=%b dst=%h expected %h", ex_pc, ex_en, ex_dst_addr, exp_pass);
            end
        end
        set_idle();
    endtask

    task automatic test_md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
        int n;
        int bub;
        logic [2:0]  exc;
        logic [29:0] pc;
        logic [4:0]  dst;
        exc = 3'($urandom_range(0, 2));
        drive(op, a, b, exc);
        pc = id_pc; dst = id_dst_addr;
        n = 0; bub = 0;
        #1;
        while (ex_stall_req === 1'b1 && n < 100) begin
            n++;
            step();
            if (ex_en !== 1'b0) bub++;
        end
        vectors++;
        if (n != 33) begin miscompares++; $display("FAIL md_stall_len op=%0d got %0d cycles expected 33", op, n); end
        vectors++;
        if (bub != 0) begin miscompares++; $display("FAIL md_bubbles op=%0d got %0d valid cycles expected 0", op, bub); end
        vectors++;
        if (fwd_data !== expected) begin miscompares++; $display("FAIL md_fwd op=%0d got %h expected %h", op, fwd_data, expected); end
        step();
        vectors++;
        if (ex_out !== expected || ex_en !== 1'b1 || ex_exp_code !== exc || ex_pc !== pc || ex_dst_addr !== dst) begin
            miscompares++; $display("FAIL md_load op=%0d a=%h b=%h got %h en=%b exp=%0d expected %h/1/%0d", op, a, b, ex_out, ex_en, ex_exp_code, expected, exc);
        end
        set_idle();
    endtask

    task automatic test_flush();
        int bad;
        drive(ALU_OP_MULU, $urandom | 32'h1, $urandom | 32'h1, 3'd0);
        repeat (10) step();
        flush = 1'b1;
        set_idle();
        step();
        flush = 1'b0;
        #1;
        vectors++;
        if (ex_stall_req !== 1'b0 || ex_en !== 1'b0) begin
            miscompares++; $display("FAIL flush_idle got stall=%b en=%b expected 0/0", ex_stall_req, ex_en);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ex_en !== 1'b0 || ex_stall_req !== 1'b0 || ex_out !== 32'd0 || fwd_data !== 32'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL flush_no_result got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_stall_done();
        logic [31:0] a, b, prod;
        a = $urandom | 32'h1;
        b = $urandom | 32'h1;
        prod = ref_result(ALU_OP_MULU, a, b);
        drive(ALU_OP_MULU, a, b, 3'd0);
        for (int c = 0; c <= 41; c++) begin
            stall = (c >= 30 && c <= 40);
            #1;
            vectors++;
            if (ex_stall_req !== (c <= 32)) begin
                miscompares++; $display("FAIL stall_req cycle T+%0d got %b expected %b", c, ex_stall_req, (c <= 32));
            end
            if (c >= 1) begin
                vectors++;
                if (ex_en !== 1'b0 || ex_out !== 32'd0) begin
                    miscompares++; $display("FAIL stall_hold cycle T+%0d got en=%b out=%h expected 0/0", c, ex_en, ex_out);
                end
            end
            if (c >= 33) begin
                vectors++;
                if (fwd_data !== prod) begin
                    miscompares++; $display("FAIL stall_done_fwd cycle T+%0d got %h expected %h", c, fwd_data, prod);
                end
            end
            step();
        end
        stall = 1'b0;
        vectors++;
        if (ex_out !== prod || ex_en !== 1'b1) begin
            miscompares++; $display("FAIL stall_release got %h en=%b expected %h/1", ex_out, ex_en, prod);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [3:0]  op;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
`ifdef EX_DIVIDER_EN
            op = 4'($urandom_range(10, 12));
`else
            op = ALU_OP_MULU;
`endif
            test_md_op(op, a, b, ref_result(op, a, b));
        end
        // A single-cycle op immediately after the engine releases.
        drive(ALU_OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 3'd0);
        step();
        vectors++;
        if (ex_out !== 32'hAA55_F0F0 || ex_en !== 1'b1) begin
            miscompares++; $display("FAIL b2b_xor got %h en=%b expected aa55f0f0/1", ex_out, ex_en);
        end
        set_idle();
    endtask

    task automatic test_divider();
`ifdef EX_DIVIDER_EN
        test_md_op(ALU_OP_DIVU, 32'd100, 32'd7, 32'd14);
        test_md_op(ALU_OP_REMU, 32'd100, 32'd7, 32'd2);
        test_md_op(ALU_OP_DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
        test_md_op(ALU_OP_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
`else
        for (int k = 0; k < 2; k++) begin
            drive((k == 0) ? ALU_OP_DIVU : ALU_OP_REMU, 32'd100, 32'd7, 3'd0);
            #1;
            vectors++;
            if (ex_stall_req !== 1'b0 || fwd_data !== 32'd0) begin
                miscompares++; $display("FAIL div_off_comb k=%0d got stall=%b fwd=%h expected 0/0", k, ex_stall_req, fwd_data);
            end
            step();
            vectors++;
            if (ex_out !== 32'd0 || ex_en !== 1'b1) begin
                miscompares++; $display("FAIL div_off_load k=%0d got %h en=%b expected 0/1", k, ex_out, ex_en);
            end
        end
        set_idle();
`endif
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_md_op(ALU_OP_MULU, 32'h0001_0003, 32'h0000_1005, 32'h1005_300F);
        test_md_op(ALU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        test_flush();
        test_stall_done();
        test_back_to_back();
        test_divider();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- EX stage of the 5-stage CPU. It consumes the ID/EX pipeline register outputs and performs the ALU operation, including new iterative multiply (and optional divide).
- It loads the EX/MEM pipeline register and raises a stall request to the pipeline controller while a multi-cycle operation is in flight.
- It sits directly downstream of the ID/EX register and upstream of the MEM stage.

Parameters:
- MD_ITER, 32, number of iteration cycles of the multiply/divide engine (one bit per cycle).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous active-high reset.
- id_pc  in  30  PC of instruction in ID/EX.
- id_en  in  1  ID/EX entry valid.
- id_alu_op  in  4  ALU opcode.
- id_alu_in_0, id_alu_in_1  in  32 each  ALU operands.
- id_br_flag  in  1  branch flag, passed through.
- id_mem_op  in  2  memory operation, passed through.
- id_mem_wr_data  in  32  store data, passed through.
- id_ctrl_op  in  2  control operation, passed through.
- id_dst_addr  in  5  GPR write address.
- id_gpr_we_  in  1  GPR write enable, active low.
- id_exp_code  in  3  upstream exception code.
- stall  in  1  hold EX/MEM register (from controller).
- flush  in  1  clear EX/MEM register and abort engine.
- fwd_data  out  32  combinational ALU/engine result for forwarding to ID.
- ex_stall_req  out  1  combinational stall request to controller.
- ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_  out  (widths as the corresponding id_* inputs)  registered EX/MEM copies.
- ex_exp_code  out  3  registered exception code.
- ex_out  out  32  registered result.

Behaviour:
- Reset (synchronous, high) sets:
  - ex_pc=0, ex_en=0, ex_br_flag=0, ex_mem_op=MEM_OP_NOP, ex_mem_wr_data=0
  - ex_ctrl_op=CTRL_OP_NOP, ex_dst_addr=0, ex_gpr_we_=1 (disabled), ex_exp_code=ISA_EXP_NO_EXP, ex_out=0
  - engine state=IDLE, iteration count=0.
- Single-cycle ops (NOP, AND, OR, XOR, ADDS, ADDU, SUBS, SUBU, SHRL, SHLL) keep their existing encodings.
  - Shift amount = in_1[4:0].
  - Result is 32-bit modulo.
- Overflow:
  - ADDS flags signed overflow when the operands have the same sign and the result sign differs.
  - SUBS flags signed overflow when the operands have different signs and the result sign differs from in_0.
  - On overflow, if id_exp_code==NO_EXP then ex_exp_code=ISA_EXP_OVERFLOW; otherwise the upstream code is kept.
- MULU (4'd10): lower 32 bits of the unsigned product, computed by a shift-add engine.
- Engine states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when id_en=1, op is multi-cycle, and flush=0. Operands are latched and count is set to 0.
  - BUSY: one iteration per cycle. When count==MD_ITER-1, go to DONE; otherwise count+1.
  - DONE -> IDLE when stall=0. Stay in DONE while stall=1; the result is held.
  - flush in any state -> IDLE. Partial results are discarded.
- ex_stall_req=1 when (IDLE and a multi-cycle op is pending) or state==BUSY. It is 0 in DONE.
- Latency: with the op entering ID/EX at cycle T, ex_stall_req is high for cycles T..T+32. The result is loaded at the edge ending cycle T+33, then visible on ex_out. This assumes stall=0 and MD_ITER=32.
- EX/MEM register update priority: reset > stall (hold all) > flush (load reset values) > ex_stall_req=1 (load bubble: reset values) > normal load.
- fwd_data = single-cycle result, or the engine result in DONE.
- The pipeline controller must hold ID/EX while ex_stall_req=1. This block does not rely on that for correctness beyond operand latching.

Optional Feature:
- Macro: EX_DIVIDER_EN.
- Defined: adds DIVU (4'd11) and REMU (4'd12) using a restoring divider in the same engine with identical latency.
  - Divide by zero gives DIVU=32'hFFFF_FFFF and REMU=in_0.
  - Divide by zero raises no exception.
- Undefined: codes 11/12 are treated as NOP (result 0, no stall). No divider logic is synthesised.

Decomposition:
- Shared package additions in the cpu header:
  - ALU_OP_MULU, ALU_OP_DIVU, ALU_OP_REMU
  - MdStateBus (2 bits) with MD_STATE_IDLE/BUSY/DONE
  - MdCntBus (5 bits)
- Sub-module ex_md_unit: iterative multiply/divide engine with start/abort/busy/done/result interface. The parent holds the ALU and the EX/MEM register.

Test Plan:
1. ADDU 0x0000_0003 + 0xFFFF_FFFF, stall=0 -> next cycle ex_out=0x0000_0002, ex_en=1, ex_exp_code=NO_EXP.
2. ADDS 0x7FFF_FFFF + 1 -> ex_out=0x8000_0000, ex_exp_code=ISA_EXP_OVERFLOW. Repeat with id_exp_code=UNDEF_INSN -> UNDEF_INSN kept.
3. MULU 0x0001_0003 * 0x0000_1005 at T -> ex_stall_req=1 for 33 cycles, ex_en=0 bubbles during T..T+32, ex_out=0x1005_300F at T+34.
4. MULU with flush pulsed at T+10 -> engine IDLE next cycle, ex_stall_req=0, ex_en=0, no result ever written.
5. MULU with stall=1 held from T+30 to T+40 -> state holds DONE, ex_* unchanged. Result loads on the first cycle with stall=0.
6. EX_DIVIDER_EN defined: DIVU 100/7 -> 14, REMU -> 2, DIVU x/0 -> 0xFFFF_FFFF. Undefined: DIVU -> ex_out=0, no stall.
